// File: rtl/set_circle_counter.sv
// Counts 8x8 grid points inside a set expression over circles A, B and C.
// A job is latched on en while idle; one grid point is tested per clock.
module set_circle_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [23:0] central,
  input  logic [11:0] radius,
  input  logic [1:0]  mode,
  output logic        busy,
  output logic        valid,
  output logic [7:0]  candidate
);

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StFlush,
    StTally,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] central_q, central_d;
  logic [11:0] radius_q, radius_d;
  logic [1:0]  mode_q, mode_d;
  logic [5:0]  idx_q, idx_d;
  logic        hit_q, hit_d;
  logic        hit_v_q, hit_v_d;
  logic [6:0]  count_q, count_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic [7:0]  cand_q, cand_d;

  logic [3:0]  px, py;
  logic        in_a, in_b, in_c;
  logic        qualifies;

  // Squared distances never exceed 225 per axis, so a 9-bit sum cannot overflow.
  function automatic logic in_circle(input logic [3:0] ptx, input logic [3:0] pty,
                                     input logic [3:0] cx, input logic [3:0] cy,
                                     input logic [3:0] r);
    logic signed [4:0] dx, dy;
    logic signed [9:0] dxe, dye, dx2, dy2;
    logic [8:0]        dist_sq;
    logic [7:0]        r_ext, r_sq;
    dx      = $signed({1'b0, ptx}) - $signed({1'b0, cx});
    dy      = $signed({1'b0, pty}) - $signed({1'b0, cy});
    dxe     = 10'(dx);
    dye     = 10'(dy);
    dx2     = dxe * dxe;
    dy2     = dye * dye;
    dist_sq = {1'b0, dx2[7:0]} + {1'b0, dy2[7:0]};
    r_ext   = {4'b0000, r};
    r_sq    = r_ext * r_ext;
    return dist_sq <= {1'b0, r_sq};
  endfunction

  assign px = {1'b0, idx_q[5:3]} + 4'd1;
  assign py = {1'b0, idx_q[2:0]} + 4'd1;

  assign in_a = in_circle(px, py, central_q[23:20], central_q[19:16], radius_q[11:8]);
  assign in_b = in_circle(px, py, central_q[15:12], central_q[11:8],  radius_q[7:4]);
  assign in_c = in_circle(px, py, central_q[7:4],   central_q[3:0],   radius_q[3:0]);

  always_comb begin
    qualifies = 1'b0;
    unique case (mode_q)
      2'b00: qualifies = in_a;
      2'b01: qualifies = in_a | in_b;
      2'b10: qualifies = in_a ^ in_b;
      2'b11: qualifies = (in_a & in_b & ~in_c) | (in_a & ~in_b & in_c) | (~in_a & in_b & in_c);
      default: qualifies = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    central_d = central_q;
    radius_d  = radius_q;
    mode_d    = mode_q;
    idx_d     = idx_q;
    hit_d     = hit_q;
    hit_v_d   = hit_v_q;
    count_d   = count_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    cand_d    = cand_q;

    // Membership is registered first, so the count trails the scan by one point.
    if (hit_v_q && hit_q) begin
      count_d = count_q + 7'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (en) begin
          central_d = central;
          radius_d  = radius;
          mode_d    = mode;
          count_d   = 7'd0;
          idx_d     = 6'd0;
          hit_v_d   = 1'b0;
          busy_d    = 1'b1;
          state_d   = StScan;
        end
      end
      StScan: begin
        hit_d   = qualifies;
        hit_v_d = 1'b1;
        idx_d   = idx_q + 6'd1;
        if (idx_q == 6'd63) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        hit_v_d = 1'b0;
        state_d = StTally;
      end
      StTally: begin
        cand_d  = {1'b0, count_q};
        valid_d = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      central_q <= 24'd0;
      radius_q  <= 12'd0;
      mode_q    <= 2'd0;
      idx_q     <= 6'd0;
      hit_q     <= 1'b0;
      hit_v_q   <= 1'b0;
      count_q   <= 7'd0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      cand_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      central_q <= central_d;
      radius_q  <= radius_d;
      mode_q    <= mode_d;
      idx_q     <= idx_d;
      hit_q     <= hit_d;
      hit_v_q   <= hit_v_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      cand_q    <= cand_d;
    end
  end

  assign busy      = busy_q;
  assign valid     = valid_q;
  assign candidate = cand_q;

endmodule

// File: tb/tb_set_circle_counter.sv
// Scoreboard bench for set_circle_counter: expected counts are queued at job issue
// and compared, together with latency and strobe shape, when valid appears.
module tb_set_circle_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [23:0] central;
  logic [11:0] radius;
  logic [1:0]  mode;
  logic        busy;
  logic        valid;
  logic [7:0]  candidate;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_done = 0;
  int exp_q[$];
  int acc_q[$];
  logic prev_valid = 1'b0;

  set_circle_counter dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .central   (central),
    .radius    (radius),
    .mode      (mode),
    .busy      (busy),
    .valid     (valid),
    .candidate (candidate)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference count straight from the geometric definition.
  function automatic int model(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    int cnt = 0;
    for (int x = 1; x <= 8; x++) begin
      for (int y = 1; y <= 8; y++) begin
        bit in_k [3];
        bit q;
        for (int k = 0; k < 3; k++) begin
          int cx, cy, rr;
          cx = int'(c[23-8*k -: 4]);
          cy = int'(c[19-8*k -: 4]);
          rr = int'(r[11-4*k -: 4]);
          in_k[k] = ((x - cx) * (x - cx) + (y - cy) * (y - cy)) <= rr * rr;
        end
        case (m)
          2'd0: q = in_k[0];
          2'd1: q = in_k[0] | in_k[1];
          2'd2: q = in_k[0] ^ in_k[1];
          default: q = (int'(in_k[0]) + int'(in_k[1]) + int'(in_k[2])) == 2;
        endcase
        if (q) cnt++;
      end
    end
    return cnt;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid) check_eq("busy_after_valid", {31'd0, busy}, 0);
      if (valid) begin
        check_eq("valid_one_cycle", {31'd0, prev_valid}, 0);
        check_eq("busy_with_valid", {31'd0, busy}, 1);
        if (exp_q.size() == 0) begin
          check_eq("spurious_valid", {31'd0, valid}, 0);
        end else begin
          check_eq("candidate", {24'd0, candidate}, exp_q.pop_front());
          check_eq("latency", cyc - acc_q.pop_front(), 66);
          n_done++;
        end
      end
      prev_valid = valid;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                       input int expv);
    for (int i = 0; i < 300; i++) begin
      if (busy == 1'b0) break;
      step();
    end
    check_eq("idle_before_issue", {31'd0, busy}, 0);
    central = c;
    radius  = r;
    mode    = m;
    en      = 1'b1;
    exp_q.push_back(expv);
    acc_q.push_back(cyc + 1);
    step();
    en = 1'b0;
    check_eq("busy_rise", {31'd0, busy}, 1);
  endtask

  task automatic wait_done();
    int start;
    start = n_done;
    for (int i = 0; i < 120; i++) begin
      if (n_done != start) break;
      step();
    end
    check_eq("done_in_time", n_done - start, 1);
  endtask

  task automatic run_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                         input int expv);
    issue(c, r, m, expv);
    wait_done();
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    central = 24'd0;
    radius  = 12'd0;
    mode    = 2'd0;
    repeat (3) step();
    check_eq("rst_busy", {31'd0, busy}, 0);
    check_eq("rst_valid", {31'd0, valid}, 0);
    check_eq("rst_candidate", {24'd0, candidate}, 0);
    rst = 1'b0;
    step();

    run_job(24'h440000, 12'h200, 2'd0, 13);
    run_job(24'h440000, 12'h000, 2'd0, 1);
    run_job(24'h110000, 12'h100, 2'd0, 3);
    run_job(24'h440000, 12'hF00, 2'd0, 64);
    run_job(24'h000000, 12'h000, 2'd0, 0);
    run_job(24'h940000, 12'h100, 2'd0, 1);
    run_job(24'h444400, 12'h220, 2'd1, 13);
    run_job(24'h118800, 12'h110, 2'd1, 6);
    run_job(24'h444400, 12'h220, 2'd2, 0);
    run_job(24'h118800, 12'h110, 2'd2, 6);
    run_job(24'h444400, 12'h200, 2'd2, 12);
    run_job(24'h444488, 12'h221, 2'd3, 13);
    run_job(24'h444444, 12'h222, 2'd3, 0);

    // en pulses and input churn while busy must not disturb the latched job.
    issue(24'h440000, 12'h200, 2'd0, 13);
    for (int i = 0; i < 8; i++) begin
      central = 24'($urandom);
      radius  = 12'($urandom);
      mode    = 2'($urandom);
      en      = i[0];
      step();
    end
    en = 1'b0;
    wait_done();
    // en in the cycle valid is high (busy about to fall) is dropped.
    en = 1'b1;
    step();
    en = 1'b0;
    check_eq("en_at_busy_fall", {31'd0, busy}, 0);

    // Reset mid-scan aborts the job with no result.
    issue(24'h118800, 12'h110, 2'd1, 6);
    repeat (20) step();
    rst = 1'b1;
    step();
    check_eq("midrst_busy", {31'd0, busy}, 0);
    check_eq("midrst_valid", {31'd0, valid}, 0);
    check_eq("midrst_candidate", {24'd0, candidate}, 0);
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    step();
    run_job(24'h444488, 12'h221, 2'd3, 13);

    for (int j = 0; j < 64; j++) begin
      logic [23:0] c;
      logic [11:0] r;
      logic [1:0]  m;
      c = 24'($urandom);
      r = 12'($urandom);
      m = 2'($urandom);
      run_job(c, r, m, model(c, r, m));
    end

    repeat (3) step();
    check_eq("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
